id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_if.sv | 51 +++++
 rtl/id_ex_stage.sv | 85 ++++++++
 tb/tb_id_ex_stage.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// Bundles the ID-side inputs and the registered EX-side outputs of the ID/EX
// pipeline register together with its freeze requests.
interface id_ex_stage_if;
  logic [2:0]  id_readREG1;
  logic [2:0]  id_readREG2;
  logic [2:0]  id_writeREG;
  logic [15:0] id_data1;
  logic [15:0] id_data2;
  logic [15:0] id_imm;
  logic        id_regwr;
  logic        id_memrd;
  logic        id_memwr;
  logic        id_alusrc;
  logic [2:0]  id_aluop;
  logic        id_valid;
  logic        id_use2;
  logic        flush;

  logic [2:0]  ID_EX_readREG1;
  logic [2:0]  ID_EX_readREG2;
  logic [2:0]  ID_EX_writeREG;
  logic [15:0] ID_EX_data1;
  logic [15:0] ID_EX_data2;
  logic [15:0] ID_EX_imm;
  logic        ID_EX_regwr;
  logic        ID_EX_memrd;
  logic        ID_EX_memwr;
  logic        ID_EX_alusrc;
  logic [2:0]  ID_EX_aluop;
  logic        ID_EX_valid;
  logic        pc_hold;
  logic        ifid_hold;

  modport master (
    output id_readREG1, id_readREG2, id_writeREG, id_data1, id_data2, id_imm,
           id_regwr, id_memrd, id_memwr, id_alusrc, id_aluop, id_valid,
           id_use2, flush,
    input  ID_EX_readREG1, ID_EX_readREG2, ID_EX_writeREG, ID_EX_data1,
           ID_EX_data2, ID_EX_imm, ID_EX_regwr, ID_EX_memrd, ID_EX_memwr,
           ID_EX_alusrc, ID_EX_aluop, ID_EX_valid, pc_hold, ifid_hold
  );

  modport slave (
    input  id_readREG1, id_readREG2, id_writeREG, id_data1, id_data2, id_imm,
           id_regwr, id_memrd, id_memwr, id_alusrc, id_aluop, id_valid,
           id_use2, flush,
    output ID_EX_readREG1, ID_EX_readREG2, ID_EX_writeREG, ID_EX_data1,
           ID_EX_data2, ID_EX_imm, ID_EX_regwr, ID_EX_memrd, ID_EX_memwr,
           ID_EX_alusrc, ID_EX_aluop, ID_EX_valid, pc_hold, ifid_hold
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and flush bubbles.
// Define ID_EX_STALLCNT_EN to add the saturating stall_cnt output.
module id_ex_stage (
  input  logic           clk,
  input  logic           rst_n,
  id_ex_stage_if.slave   bus
`ifdef ID_EX_STALLCNT_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);

  logic hazard;
  logic bubble;
  logic hold;

  // A load in EX whose destination the ID instruction reads must wait one
  // cycle; r0 is hardwired so a load targeting it never blocks anyone.
  assign hazard = bus.ID_EX_valid && bus.ID_EX_memrd &&
                  (bus.ID_EX_writeREG != 3'd0) && bus.id_valid &&
                  ((bus.ID_EX_writeREG == bus.id_readREG1) ||
                   (bus.id_use2 && (bus.ID_EX_writeREG == bus.id_readREG2)));

  // Flush wins: the held instruction is being discarded anyway.
  assign hold          = hazard && !bus.flush;
  assign bubble        = hazard || bus.flush;
  assign bus.pc_hold   = hold;
  assign bus.ifid_hold = hold;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ID_EX_readREG1 <= '0;
      bus.ID_EX_readREG2 <= '0;
      bus.ID_EX_writeREG <= '0;
      bus.ID_EX_data1    <= '0;
      bus.ID_EX_data2    <= '0;
      bus.ID_EX_imm      <= '0;
      bus.ID_EX_regwr    <= 1'b0;
      bus.ID_EX_memrd    <= 1'b0;
      bus.ID_EX_memwr    <= 1'b0;
      bus.ID_EX_alusrc   <= 1'b0;
      bus.ID_EX_aluop    <= '0;
      bus.ID_EX_valid    <= 1'b0;
    end else if (bubble) begin
      bus.ID_EX_readREG1 <= '0;
      bus.ID_EX_readREG2 <= '0;
      bus.ID_EX_writeREG <= '0;
      bus.ID_EX_data1    <= '0;
      bus.ID_EX_data2    <= '0;
      bus.ID_EX_imm      <= '0;
      bus.ID_EX_regwr    <= 1'b0;
      bus.ID_EX_memrd    <= 1'b0;
      bus.ID_EX_memwr    <= 1'b0;
      bus.ID_EX_alusrc   <= 1'b0;
      bus.ID_EX_aluop    <= '0;
      bus.ID_EX_valid    <= 1'b0;
    end else begin
      bus.ID_EX_readREG1 <= bus.id_readREG1;
      bus.ID_EX_readREG2 <= bus.id_readREG2;
      bus.ID_EX_writeREG <= bus.id_writeREG;
      bus.ID_EX_data1    <= bus.id_data1;
      bus.ID_EX_data2    <= bus.id_data2;
      bus.ID_EX_imm      <= bus.id_imm;
      // Side-effecting controls of a non-instruction must never reach EX.
      bus.ID_EX_regwr    <= bus.id_regwr && bus.id_valid;
      bus.ID_EX_memrd    <= bus.id_memrd && bus.id_valid;
      bus.ID_EX_memwr    <= bus.id_memwr && bus.id_valid;
      bus.ID_EX_alusrc   <= bus.id_alusrc;
      bus.ID_EX_aluop    <= bus.id_aluop;
      bus.ID_EX_valid    <= bus.id_valid;
    end
  end

`ifdef ID_EX_STALLCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (hold && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, reset and
// counter corner cases, then random traffic against a behavioural model.
module tb_id_ex_stage;

  typedef struct packed {
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [2:0]  wr;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] imm;
    logic        regwr;
    logic        memrd;
    logic        memwr;
    logic        alusrc;
    logic [2:0]  aluop;
    logic        valid;
  } ex_t;

  typedef struct {
    logic       v;
    logic       rd;
    logic [2:0] wr;
    logic [2:0] r1;
    logic [2:0] r2;
    logic       u2;
    logic       fl;
    logic       x_hold;
    logic       x_valid;
    logic [2:0] x_r1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  id_ex_stage_if bus ();
`ifdef ID_EX_STALLCNT_EN
  logic [15:0] stall_cnt;
`endif

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef ID_EX_STALLCNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_err    = 0;
  ex_t  m_ex;
  int   m_cnt;
  logic last_hold;
  vec_t tbl[18];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ex_t dut_state();
    ex_t s;
    s.r1     = bus.ID_EX_readREG1;
    s.r2     = bus.ID_EX_readREG2;
    s.wr     = bus.ID_EX_writeREG;
    s.d1     = bus.ID_EX_data1;
    s.d2     = bus.ID_EX_data2;
    s.imm    = bus.ID_EX_imm;
    s.regwr  = bus.ID_EX_regwr;
    s.memrd  = bus.ID_EX_memrd;
    s.memwr  = bus.ID_EX_memwr;
    s.alusrc = bus.ID_EX_alusrc;
    s.aluop  = bus.ID_EX_aluop;
    s.valid  = bus.ID_EX_valid;
    return s;
  endfunction

  task automatic drive(input ex_t i, input logic use2, input logic fl);
    bus.id_readREG1 = i.r1;
    bus.id_readREG2 = i.r2;
    bus.id_writeREG = i.wr;
    bus.id_data1    = i.d1;
    bus.id_data2    = i.d2;
    bus.id_imm      = i.imm;
    bus.id_regwr    = i.regwr;
    bus.id_memrd    = i.memrd;
    bus.id_memwr    = i.memwr;
    bus.id_alusrc   = i.alusrc;
    bus.id_aluop    = i.aluop;
    bus.id_valid    = i.valid;
    bus.id_use2     = use2;
    bus.flush       = fl;
  endtask

  // Reference: a consumer must wait while the instruction one ahead is a real
  // load into a nonzero register that the consumer actually reads.
  function automatic logic must_wait(input ex_t ahead, input ex_t i, input logic use2);
    logic reads_it;
    reads_it = (i.r1 == ahead.wr) || (use2 && (i.r2 == ahead.wr));
    return ahead.valid && ahead.memrd && (ahead.wr != 0) && i.valid && reads_it;
  endfunction

  function automatic ex_t next_ex(input ex_t i, input logic use2, input logic fl);
    ex_t n;
    if (fl || must_wait(m_ex, i, use2)) return '0;
    n = i;
    if (!i.valid) begin
      n.regwr = 1'b0;
      n.memrd = 1'b0;
      n.memwr = 1'b0;
    end
    return n;
  endfunction

  // Called at posedge+1: drive, check freeze mid-cycle, clock, check state.
  task automatic cycle(input ex_t i, input logic use2, input logic fl, input string tag);
    logic exp_hold;
    drive(i, use2, fl);
    @(negedge clk);
    exp_hold = must_wait(m_ex, i, use2) && !fl;
    last_hold = bus.pc_hold;
    check({tag, " pc_hold"}, 80'(bus.pc_hold), 80'(exp_hold));
    check({tag, " ifid_hold"}, 80'(bus.ifid_hold), 80'(exp_hold));
    @(posedge clk);
    m_ex = next_ex(i, use2, fl);
    if (exp_hold && m_cnt < 65535) m_cnt++;
    #1;
    check({tag, " ex_state"}, 80'(dut_state()), 80'(m_ex));
`ifdef ID_EX_STALLCNT_EN
    check({tag, " stall_cnt"}, 80'(stall_cnt), 80'(m_cnt));
`endif
  endtask

  function automatic ex_t rand_instr();
    ex_t i;
    i.r1     = 3'($urandom_range(0, 3));
    i.r2     = 3'($urandom_range(0, 3));
    i.wr     = 3'($urandom_range(0, 3));
    i.d1     = 16'($urandom);
    i.d2     = 16'($urandom);
    i.imm    = 16'($urandom);
    i.regwr  = 1'($urandom);
    i.memrd  = ($urandom_range(0, 9) < 4);
    i.memwr  = 1'($urandom);
    i.alusrc = 1'($urandom);
    i.aluop  = 3'($urandom);
    i.valid  = ($urandom_range(0, 9) < 8);
    return i;
  endfunction

  function automatic vec_t mk(input logic v, rd, input logic [2:0] wr, r1, r2,
                              input logic u2, fl, xh, xv, input logic [2:0] xr1);
    vec_t t;
    t.v = v; t.rd = rd; t.wr = wr; t.r1 = r1; t.r2 = r2; t.u2 = u2; t.fl = fl;
    t.x_hold = xh; t.x_valid = xv; t.x_r1 = xr1;
    return t;
  endfunction

  function automatic ex_t load_of(input logic [2:0] wr, input logic [2:0] r1, input logic [15:0] d1);
    ex_t i;
    i = '0;
    i.valid = 1'b1; i.memrd = 1'b1; i.regwr = 1'b1; i.wr = wr; i.r1 = r1; i.d1 = d1;
    return i;
  endfunction

  initial begin
    ex_t i;
    //        v  rd wr r1 r2 u2 fl  hold valid r1
    tbl[0]  = mk(1, 1, 3, 1, 0, 0, 0, 0, 1, 1);  // load r3
    tbl[1]  = mk(1, 0, 1, 3, 2, 1, 0, 1, 0, 0);  // add r1<-r3,r2 stalls
    tbl[2]  = mk(1, 0, 1, 3, 2, 1, 0, 0, 1, 3);  // add re-presented
    tbl[3]  = mk(1, 1, 0, 4, 0, 0, 0, 0, 1, 4);  // load r0
    tbl[4]  = mk(1, 0, 2, 0, 0, 0, 0, 0, 1, 0);  // reader of r0: no stall
    tbl[5]  = mk(1, 1, 5, 6, 0, 0, 0, 0, 1, 6);  // load r5
    tbl[6]  = mk(1, 0, 1, 1, 5, 0, 0, 0, 1, 1);  // r5 on rs2, use2=0
    tbl[7]  = mk(1, 1, 5, 2, 0, 0, 0, 0, 1, 2);  // load r5
    tbl[8]  = mk(1, 0, 1, 1, 5, 1, 0, 1, 0, 0);  // r5 on rs2, use2=1
    tbl[9]  = mk(1, 0, 1, 1, 5, 1, 0, 0, 1, 1);
    tbl[10] = mk(1, 1, 3, 7, 0, 0, 0, 0, 1, 7);  // load r3
    tbl[11] = mk(1, 0, 1, 3, 0, 0, 1, 0, 0, 0);  // hazard + flush
    tbl[12] = mk(1, 1, 2, 1, 0, 0, 0, 0, 1, 1);  // load r2
    tbl[13] = mk(1, 1, 4, 2, 0, 0, 0, 1, 0, 0);  // load r4 <- r2
    tbl[14] = mk(1, 1, 4, 2, 0, 0, 0, 0, 1, 2);
    tbl[15] = mk(1, 0, 1, 4, 0, 0, 0, 1, 0, 0);  // consumer of r4
    tbl[16] = mk(1, 0, 1, 4, 0, 0, 0, 0, 1, 4);
    tbl[17] = mk(0, 1, 6, 3, 0, 0, 0, 0, 0, 3);  // invalid slot

    rst_n = 1'b0;
    m_ex  = '0;
    m_cnt = 0;
    drive('0, 1'b0, 1'b0);
    #2;
    check("reset ex_state", 80'(dut_state()), 80'(0));
    check("reset pc_hold", 80'(bus.pc_hold), 80'(0));
    check("reset ifid_hold", 80'(bus.ifid_hold), 80'(0));
`ifdef ID_EX_STALLCNT_EN
    check("reset stall_cnt", 80'(stall_cnt), 80'(0));
`endif
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      i        = rand_instr();
      i.valid  = tbl[k].v;
      i.memrd  = tbl[k].rd;
      i.regwr  = 1'b1;
      i.memwr  = 1'b0;
      i.wr     = tbl[k].wr;
      i.r1     = tbl[k].r1;
      i.r2     = tbl[k].r2;
      cycle(i, tbl[k].u2, tbl[k].fl, $sformatf("vec%0d", k));
      check($sformatf("vec%0d hold", k), 80'(last_hold), 80'(tbl[k].x_hold));
      check($sformatf("vec%0d valid", k), 80'(bus.ID_EX_valid), 80'(tbl[k].x_valid));
      check($sformatf("vec%0d readREG1", k), 80'(bus.ID_EX_readREG1), 80'(tbl[k].x_r1));
    end

    // Reset asserted in the middle of a stall cycle.
    cycle(load_of(3'd3, 3'd0, 16'h1234), 1'b0, 1'b0, "midrst load");
    check("midrst data1", 80'(bus.ID_EX_data1), 80'(16'h1234));
    i = '0;
    i.valid = 1'b1; i.regwr = 1'b1; i.wr = 3'd1; i.r1 = 3'd3;
    drive(i, 1'b0, 1'b0);
    @(negedge clk);
    check("midrst stall seen", 80'(bus.pc_hold), 80'(1));
    rst_n = 1'b0;
    #1;
    check("midrst ex_state", 80'(dut_state()), 80'(0));
    check("midrst pc_hold", 80'(bus.pc_hold), 80'(0));
    check("midrst ifid_hold", 80'(bus.ifid_hold), 80'(0));
`ifdef ID_EX_STALLCNT_EN
    check("midrst stall_cnt", 80'(stall_cnt), 80'(0));
`endif
    m_ex  = '0;
    m_cnt = 0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    m_ex = next_ex(i, 1'b0, 1'b0);
    #1;
    check("postrst ex_state", 80'(dut_state()), 80'(m_ex));

`ifdef ID_EX_STALLCNT_EN
    force dut.stall_cnt = 16'hFFFE;
    #1 release dut.stall_cnt;
    m_cnt = 65534;
    for (int s = 0; s < 3; s++) begin
      cycle(load_of(3'd2, 3'd0, 16'h0), 1'b0, 1'b0, "sat load");
      i = '0;
      i.valid = 1'b1; i.r1 = 3'd2;
      cycle(i, 1'b0, 1'b0, "sat stall");
      cycle(i, 1'b0, 1'b0, "sat pass");
    end
    check("sat final", 80'(stall_cnt), 80'(16'hFFFF));
`endif

    for (int n = 0; n < 400; n++)
      cycle(rand_instr(), 1'($urandom), ($urandom_range(0, 9) == 0), "rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
